// File: rtl/vga_axil_arbiter.sv
// vga_axil_arbiter: shares one downstream AXI4-Lite slave between N_MASTERS masters,
// with independent read and write FSMs. Macro VGA_AXIL_ARBITER_RR_EN selects round-robin.
module vga_axil_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int IDX_W     = $clog2(N_MASTERS),
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  // Upstream ports, one lane per master (flattened vga_axil_if slave side)
  input  logic [N_MASTERS-1:0][ADDR_W-1:0]   s_araddr_i,
  input  logic [N_MASTERS-1:0]               s_arvalid_i,
  output logic [N_MASTERS-1:0]               s_arready_o,
  output logic [N_MASTERS-1:0][DATA_W-1:0]   s_rdata_o,
  output logic [N_MASTERS-1:0][1:0]          s_rresp_o,
  output logic [N_MASTERS-1:0]               s_rvalid_o,
  input  logic [N_MASTERS-1:0]               s_rready_i,
  input  logic [N_MASTERS-1:0][ADDR_W-1:0]   s_awaddr_i,
  input  logic [N_MASTERS-1:0]               s_awvalid_i,
  output logic [N_MASTERS-1:0]               s_awready_o,
  input  logic [N_MASTERS-1:0][DATA_W-1:0]   s_wdata_i,
  input  logic [N_MASTERS-1:0][DATA_W/8-1:0] s_wstrb_i,
  input  logic [N_MASTERS-1:0]               s_wvalid_i,
  output logic [N_MASTERS-1:0]               s_wready_o,
  output logic [N_MASTERS-1:0][1:0]          s_bresp_o,
  output logic [N_MASTERS-1:0]               s_bvalid_o,
  input  logic [N_MASTERS-1:0]               s_bready_i,
  // Downstream port to the shared slave (flattened vga_axil_if master side)
  output logic [ADDR_W-1:0]                  m_araddr_o,
  output logic                               m_arvalid_o,
  input  logic                               m_arready_i,
  input  logic [DATA_W-1:0]                  m_rdata_i,
  input  logic [1:0]                         m_rresp_i,
  input  logic                               m_rvalid_i,
  output logic                               m_rready_o,
  output logic [ADDR_W-1:0]                  m_awaddr_o,
  output logic                               m_awvalid_o,
  input  logic                               m_awready_i,
  output logic [DATA_W-1:0]                  m_wdata_o,
  output logic [DATA_W/8-1:0]                m_wstrb_o,
  output logic                               m_wvalid_o,
  input  logic                               m_wready_i,
  input  logic [1:0]                         m_bresp_i,
  input  logic                               m_bvalid_i,
  output logic                               m_bready_o,
  // FSM observation
  output logic [1:0]                         rd_state_o,
  output logic [1:0]                         wr_state_o,
  output logic [IDX_W-1:0]                   rd_gnt_o,
  output logic [IDX_W-1:0]                   wr_gnt_o
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and in ADDR/RESP both travel combinationally between
  // the granted master lane and the downstream port. IDLE drives no ready or valid.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           rd_state_q, rd_state_d;
  state_e           wr_state_q, wr_state_d;
  logic [IDX_W-1:0] rgnt_q, rgnt_d;
  logic [IDX_W-1:0] wgnt_q, wgnt_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [IDX_W-1:0] rd_start, wr_start;
  logic [IDX_W-1:0] rd_pick, wr_pick;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N_MASTERS - 1)) ? '0 : v + 1'b1;
  endfunction

  // First requester found scanning upward from start, wrapping at N_MASTERS.
  function automatic logic [IDX_W-1:0] arb_pick(input logic [N_MASTERS-1:0] req,
                                                input logic [IDX_W-1:0]     start);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sel;
    logic             found;
    idx   = start;
    sel   = start;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return sel;
  endfunction

  assign rd_pick = arb_pick(s_arvalid_i, rd_start);
  assign wr_pick = arb_pick(s_awvalid_i, wr_start);

`ifdef VGA_AXIL_ARBITER_RR_EN
  // Pointers hold the next starting index (last grant + 1); zero after reset.
  logic [IDX_W-1:0] rptr_q, rptr_d;
  logic [IDX_W-1:0] wptr_q, wptr_d;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    if (rd_state_q == ST_IDLE && |s_arvalid_i) rptr_d = wrap_inc(rd_pick);
    if (wr_state_q == ST_IDLE && |s_awvalid_i) wptr_d = wrap_inc(wr_pick);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
    end
  end

  assign rd_start = rptr_q;
  assign wr_start = wptr_q;
`else
  assign rd_start = '0;
  assign wr_start = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_state_q <= ST_IDLE;
      wr_state_q <= ST_IDLE;
      rgnt_q     <= '0;
      wgnt_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      rgnt_q     <= rgnt_d;
      wgnt_q     <= wgnt_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Read path
  always_comb begin
    rd_state_d  = rd_state_q;
    rgnt_d      = rgnt_q;
    m_araddr_o  = '0;
    m_arvalid_o = 1'b0;
    m_rready_o  = 1'b0;
    s_arready_o = '0;
    s_rdata_o   = '0;
    s_rresp_o   = '0;
    s_rvalid_o  = '0;
    case (rd_state_q)
      ST_IDLE: begin
        if (|s_arvalid_i) begin
          rgnt_d     = rd_pick;
          rd_state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_araddr_o          = s_araddr_i[rgnt_q];
        m_arvalid_o         = s_arvalid_i[rgnt_q];
        s_arready_o[rgnt_q] = m_arready_i;
        if (m_arvalid_o && m_arready_i) rd_state_d = ST_RESP;
      end
      ST_RESP: begin
        s_rdata_o[rgnt_q]  = m_rdata_i;
        s_rresp_o[rgnt_q]  = m_rresp_i;
        s_rvalid_o[rgnt_q] = m_rvalid_i;
        m_rready_o         = s_rready_i[rgnt_q];
        if (m_rvalid_i && m_rready_o) rd_state_d = ST_IDLE;
      end
      default: rd_state_d = ST_IDLE;
    endcase
  end

  // Write path: AW and W complete independently; a finished channel is masked off.
  always_comb begin
    wr_state_d  = wr_state_q;
    wgnt_d      = wgnt_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    m_awaddr_o  = '0;
    m_awvalid_o = 1'b0;
    m_wdata_o   = '0;
    m_wstrb_o   = '0;
    m_wvalid_o  = 1'b0;
    m_bready_o  = 1'b0;
    s_awready_o = '0;
    s_wready_o  = '0;
    s_bresp_o   = '0;
    s_bvalid_o  = '0;
    case (wr_state_q)
      ST_IDLE: begin
        if (|s_awvalid_i) begin
          wgnt_d     = wr_pick;
          wr_state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        m_awaddr_o          = s_awaddr_i[wgnt_q];
        m_awvalid_o         = s_awvalid_i[wgnt_q] & ~aw_done_q;
        s_awready_o[wgnt_q] = m_awready_i & ~aw_done_q;
        m_wdata_o           = s_wdata_i[wgnt_q];
        m_wstrb_o           = s_wstrb_i[wgnt_q];
        m_wvalid_o          = s_wvalid_i[wgnt_q] & ~w_done_q;
        s_wready_o[wgnt_q]  = m_wready_i & ~w_done_q;
        aw_done_d           = aw_done_q | (m_awvalid_o & m_awready_i);
        w_done_d            = w_done_q | (m_wvalid_o & m_wready_i);
        if (aw_done_d && w_done_d) begin
          wr_state_d = ST_RESP;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
        end
      end
      ST_RESP: begin
        s_bresp_o[wgnt_q]  = m_bresp_i;
        s_bvalid_o[wgnt_q] = m_bvalid_i;
        m_bready_o         = s_bready_i[wgnt_q];
        if (m_bvalid_i && m_bready_o) wr_state_d = ST_IDLE;
      end
      default: wr_state_d = ST_IDLE;
    endcase
  end

  assign rd_state_o = rd_state_q;
  assign wr_state_o = wr_state_q;
  assign rd_gnt_o   = rgnt_q;
  assign wr_gnt_o   = wgnt_q;

endmodule

// File: tb/tb_vga_axil_arbiter.sv
// Directed testbench for vga_axil_arbiter with two masters; expectations follow the
// build's arbitration mode (VGA_AXIL_ARBITER_RR_EN).
module tb_vga_axil_arbiter;
  localparam int N  = 2;
  localparam int IW = 1;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk_i = 1'b0;
  logic rst_i;

  logic [N-1:0][AW-1:0]   s_araddr_i;
  logic [N-1:0]           s_arvalid_i;
  logic [N-1:0]           s_arready_o;
  logic [N-1:0][DW-1:0]   s_rdata_o;
  logic [N-1:0][1:0]      s_rresp_o;
  logic [N-1:0]           s_rvalid_o;
  logic [N-1:0]           s_rready_i;
  logic [N-1:0][AW-1:0]   s_awaddr_i;
  logic [N-1:0]           s_awvalid_i;
  logic [N-1:0]           s_awready_o;
  logic [N-1:0][DW-1:0]   s_wdata_i;
  logic [N-1:0][DW/8-1:0] s_wstrb_i;
  logic [N-1:0]           s_wvalid_i;
  logic [N-1:0]           s_wready_o;
  logic [N-1:0][1:0]      s_bresp_o;
  logic [N-1:0]           s_bvalid_o;
  logic [N-1:0]           s_bready_i;
  logic [AW-1:0]          m_araddr_o;
  logic                   m_arvalid_o;
  logic                   m_arready_i;
  logic [DW-1:0]          m_rdata_i;
  logic [1:0]             m_rresp_i;
  logic                   m_rvalid_i;
  logic                   m_rready_o;
  logic [AW-1:0]          m_awaddr_o;
  logic                   m_awvalid_o;
  logic                   m_awready_i;
  logic [DW-1:0]          m_wdata_o;
  logic [DW/8-1:0]        m_wstrb_o;
  logic                   m_wvalid_o;
  logic                   m_wready_i;
  logic [1:0]             m_bresp_i;
  logic                   m_bvalid_i;
  logic                   m_bready_o;
  logic [1:0]             rd_state_o;
  logic [1:0]             wr_state_o;
  logic [IW-1:0]          rd_gnt_o;
  logic [IW-1:0]          wr_gnt_o;

  int n_tests = 0;
  int n_fail  = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        outs_nonzero;

  // clock/reset block
  always #5 clk_i = ~clk_i;

  vga_axil_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o),
    .s_rready_i(s_rready_i), .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i),
    .s_awready_o(s_awready_o), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_bresp_o(s_bresp_o),
    .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
    .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i),
    .m_rready_o(m_rready_o), .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o),
    .m_awready_i(m_awready_i), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_bresp_i(m_bresp_i),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .rd_state_o(rd_state_o), .wr_state_o(wr_state_o),
    .rd_gnt_o(rd_gnt_o), .wr_gnt_o(wr_gnt_o)
  );

  assign outs_nonzero = |{s_arready_o, s_rdata_o, s_rresp_o, s_rvalid_o, s_awready_o,
                          s_wready_o, s_bresp_o, s_bvalid_o, m_araddr_o, m_arvalid_o,
                          m_rready_o, m_awaddr_o, m_awvalid_o, m_wdata_o, m_wstrb_o,
                          m_wvalid_o, m_bready_o};

  // Downstream handshake monitor; inputs are stable from posedge+1 to the next posedge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (m_awvalid_o && m_awready_i) begin
        aw_hs_cnt++;
        got_q.push_back(32'(wr_gnt_o));
      end
      if (m_wvalid_o && m_wready_i) w_hs_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    s_araddr_i = '0; s_arvalid_i = '0; s_rready_i = '0;
    s_awaddr_i = '0; s_awvalid_i = '0; s_wdata_i = '0; s_wstrb_i = '0;
    s_wvalid_i = '0; s_bready_i = '0;
    m_arready_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0;
    m_awready_i = 1'b0; m_wready_i = 1'b0; m_bresp_i = '0; m_bvalid_i = 1'b0;
  endtask

  // Full read by master m with the slave answering data/resp after one AR handshake.
  task automatic do_read(input logic [IW-1:0] m, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [1:0] resp);
    s_araddr_i[m] = addr;
    s_arvalid_i[m] = 1'b1;
    #1;
    check("rd_bubble", 64'(m_arvalid_o), 64'(0));
    tick();
    check("rd_arvalid", 64'(m_arvalid_o), 64'(1));
    check("rd_araddr", 64'(m_araddr_o), 64'(addr));
    check("rd_gnt", 64'(rd_gnt_o), 64'(m));
    m_arready_i = 1'b1;
    #1;
    check("rd_arready", 64'(s_arready_o), 64'(2'b01 << m));
    tick();
    s_arvalid_i[m] = 1'b0;
    m_arready_i = 1'b0;
    m_rdata_i = data;
    m_rresp_i = resp;
    m_rvalid_i = 1'b1;
    s_rready_i[m] = 1'b1;
    #1;
    check("rd_rvalid", 64'(s_rvalid_o), 64'(2'b01 << m));
    check("rd_rdata", 64'(s_rdata_o[m]), 64'(data));
    check("rd_rresp", 64'(s_rresp_o[m]), 64'(resp));
    check("rd_other_rdata", 64'(s_rdata_o[~m]), 64'(0));
    check("rd_rready", 64'(m_rready_o), 64'(1));
    tick();
    m_rvalid_i = 1'b0;
    m_rdata_i = '0;
    s_rready_i[m] = 1'b0;
    #1;
    check("rd_idle", 64'(rd_state_o), 64'(0));
    check("rd_rvalid_idle", 64'(s_rvalid_o), 64'(0));
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    // Reset with a stray slave response present: nothing may be forwarded.
    m_rvalid_i = 1'b1;
    m_bvalid_i = 1'b1;
    tick();
    tick();
    check("rst_outs_zero", 64'(outs_nonzero), 64'(0));
    check("rst_rd_state", 64'(rd_state_o), 64'(0));
    check("rst_wr_state", 64'(wr_state_o), 64'(0));
    rst_i = 1'b0;
    #1;
    check("idle_rready", 64'(m_rready_o), 64'(0));
    check("idle_bready", 64'(m_bready_o), 64'(0));
    check("idle_rvalid", 64'(s_rvalid_o), 64'(0));
    tick();
    clear_inputs();

    // Single read by master 1
    do_read(1'b1, 32'h10, 32'hDEADBEEF, 2'b00);

    // Split write by master 0, W three cycles after AW
    aw_hs_cnt = 0;
    w_hs_cnt = 0;
    got_q.delete();
    s_awaddr_i[0] = 32'h04;
    s_awvalid_i[0] = 1'b1;
    s_wdata_i[0] = 32'h5A5A0001;
    s_wstrb_i[0] = 4'hF;
    m_awready_i = 1'b1;
    m_wready_i = 1'b1;
    #1;
    check("wr_bubble", 64'(m_awvalid_o), 64'(0));
    tick();
    check("wr_awvalid", 64'(m_awvalid_o), 64'(1));
    check("wr_awaddr", 64'(m_awaddr_o), 64'(32'h04));
    check("wr_awready", 64'(s_awready_o), 64'(2'b01));
    check("wr_wvalid_early", 64'(m_wvalid_o), 64'(0));
    tick();
    check("wr_aw_masked", 64'(m_awvalid_o), 64'(0));
    check("wr_awready_masked", 64'(s_awready_o), 64'(0));
    s_awvalid_i[0] = 1'b0;
    tick();
    s_wvalid_i[0] = 1'b1;
    #1;
    check("wr_wvalid", 64'(m_wvalid_o), 64'(1));
    check("wr_wdata", 64'(m_wdata_o), 64'(32'h5A5A0001));
    check("wr_wstrb", 64'(m_wstrb_o), 64'(4'hF));
    check("wr_wready", 64'(s_wready_o), 64'(2'b01));
    tick();
    s_wvalid_i[0] = 1'b0;
    check("wr_resp_state", 64'(wr_state_o), 64'(2));
    m_bvalid_i = 1'b1;
    m_bresp_i = 2'b00;
    s_bready_i[0] = 1'b1;
    #1;
    check("wr_bvalid", 64'(s_bvalid_o), 64'(2'b01));
    check("wr_bready", 64'(m_bready_o), 64'(1));
    tick();
    clear_inputs();
    #1;
    check("wr_idle", 64'(wr_state_o), 64'(0));
    check("wr_aw_count", 64'(aw_hs_cnt), 64'(1));
    check("wr_w_count", 64'(w_hs_cnt), 64'(1));

    // Contention: both masters write continuously, from a fresh reset
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    got_q.delete();
    exp_q.delete();
`ifdef VGA_AXIL_ARBITER_RR_EN
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
`else
    exp_q = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    s_awaddr_i[0] = 32'h40;
    s_awaddr_i[1] = 32'h44;
    s_awvalid_i = 2'b11;
    s_wvalid_i = 2'b11;
    s_wstrb_i = '1;
    s_bready_i = 2'b11;
    m_awready_i = 1'b1;
    m_wready_i = 1'b1;
    m_bvalid_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (got_q.size() >= 4) break;
    end
    s_awvalid_i = '0;
    s_wvalid_i = '0;
    tick();
    clear_inputs();
    #1;
    check("cont_count", 64'(got_q.size()), 64'(4));
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("cont_gnt_order", 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
    check("cont_wr_idle", 64'(wr_state_o), 64'(0));

    // Concurrency: master 0 writes while master 1 reads in the same cycle
    s_awaddr_i[0] = 32'h08;
    s_awvalid_i[0] = 1'b1;
    s_wdata_i[0] = 32'hCAFE0008;
    s_wvalid_i[0] = 1'b1;
    s_araddr_i[1] = 32'h0C;
    s_arvalid_i[1] = 1'b1;
    m_awready_i = 1'b1;
    m_wready_i = 1'b1;
    m_arready_i = 1'b1;
    tick();
    check("conc_arvalid", 64'(m_arvalid_o), 64'(1));
    check("conc_araddr", 64'(m_araddr_o), 64'(32'h0C));
    check("conc_awvalid", 64'(m_awvalid_o), 64'(1));
    check("conc_wvalid", 64'(m_wvalid_o), 64'(1));
    check("conc_awaddr", 64'(m_awaddr_o), 64'(32'h08));
    check("conc_gnts", 64'({rd_gnt_o, wr_gnt_o}), 64'(2'b10));
    tick();
    clear_inputs();
    m_rvalid_i = 1'b1;
    m_rdata_i = 32'h0C0C0C0C;
    m_rresp_i = 2'b10;
    m_bvalid_i = 1'b1;
    m_bresp_i = 2'b01;
    s_rready_i[1] = 1'b1;
    s_bready_i[0] = 1'b1;
    #1;
    check("conc_rvalid", 64'(s_rvalid_o), 64'(2'b10));
    check("conc_bvalid", 64'(s_bvalid_o), 64'(2'b01));
    check("conc_rresp", 64'(s_rresp_o[1]), 64'(2'b10));
    check("conc_bresp", 64'(s_bresp_o[0]), 64'(2'b01));
    check("conc_rdata", 64'(s_rdata_o[1]), 64'(32'h0C0C0C0C));
    tick();
    clear_inputs();
    #1;
    check("conc_idle", 64'({rd_state_o, wr_state_o}), 64'(0));

    // Reset in write RESP before bvalid
    s_awaddr_i[0] = 32'h20;
    s_awvalid_i[0] = 1'b1;
    s_wvalid_i[0] = 1'b1;
    m_awready_i = 1'b1;
    m_wready_i = 1'b1;
    tick();
    tick();
    clear_inputs();
    check("mid_wr_resp", 64'(wr_state_o), 64'(2));
    rst_i = 1'b1;
    tick();
    check("mid_rst_outs_zero", 64'(outs_nonzero), 64'(0));
    check("mid_rst_wr_idle", 64'(wr_state_o), 64'(0));
    rst_i = 1'b0;
    m_bvalid_i = 1'b1;
    #1;
    check("late_bready", 64'(m_bready_o), 64'(0));
    check("late_bvalid", 64'(s_bvalid_o), 64'(0));
    tick();
    m_bvalid_i = 1'b0;
    check("late_wr_idle", 64'(wr_state_o), 64'(0));
    do_read(1'b1, 32'h30, 32'h12345678, 2'b00);

    // Slave backpressure on AR while master 0 waits
    s_araddr_i[1] = 32'h14;
    s_arvalid_i[1] = 1'b1;
    tick();
    s_araddr_i[0] = 32'h18;
    s_arvalid_i[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_arvalid", 64'(m_arvalid_o), 64'(1));
      check("bp_araddr", 64'(m_araddr_o), 64'(32'h14));
      check("bp_arready", 64'(s_arready_o), 64'(0));
      tick();
    end
    m_arready_i = 1'b1;
    #1;
    check("bp_arready_m1", 64'(s_arready_o), 64'(2'b10));
    tick();
    m_arready_i = 1'b0;
    s_arvalid_i[1] = 1'b0;
    check("bp_resp_gnt", 64'(rd_gnt_o), 64'(1));
    check("bp_m0_blocked", 64'(s_arready_o), 64'(0));
    tick();
    check("bp_resp_hold", 64'(rd_state_o), 64'(2));
    m_rvalid_i = 1'b1;
    m_rdata_i = 32'hA5A5A5A5;
    s_rready_i[1] = 1'b1;
    tick();
    m_rvalid_i = 1'b0;
    s_rready_i[1] = 1'b0;
    #1;
    check("bp_gap_idle", 64'(rd_state_o), 64'(0));
    check("bp_gap_arvalid", 64'(m_arvalid_o), 64'(0));
    tick();
    check("bp_next_gnt", 64'(rd_gnt_o), 64'(0));
    check("bp_next_araddr", 64'(m_araddr_o), 64'(32'h18));
    m_arready_i = 1'b1;
    tick();
    clear_inputs();
    m_rvalid_i = 1'b1;
    s_rready_i[0] = 1'b1;
    tick();
    clear_inputs();
    #1;
    check("bp_final_idle", 64'(rd_state_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_axil_arbiter.md
# vga_axil_arbiter

Two-channel AXI4-Lite arbiter that shares one downstream AXI4-Lite slave, for example the VGA register file, between `N_MASTERS` upstream masters. The read path (AR/R) and the write path (AW/W/B) are arbitrated independently. Each path allows one outstanding transaction at a time. The block sits between the bus masters (CPU bridge, test/debug master) and the single `vga_axil_if` slave port of the VGA core.

## Interface
- `N_MASTERS`, default 2: number of upstream masters; allowed range 2..8.
- `IDX_W`, default `$clog2(N_MASTERS)`: grant index width; derived, do not override.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_i`, input, 1: synchronous, active-high reset.
- `s_axil`, `vga_axil_if.slave`, array `[N_MASTERS]`: upstream ports; the arbiter is the slave here.
- `m_axil`, `vga_axil_if.master`, 1: downstream port to the shared slave.
- The arbiter clocks only from `clk_i`/`rst_i`. The `clk_i`/`arst_ni` signals carried in the interface modports are unused.

## Operation
- **Two identical FSMs**, one for reads and one for writes. States are IDLE, ADDR and RESP. Each FSM has a registered grant index `rgnt`/`wgnt`.
- **Read request:** `s_axil[i].arvalid_i`.
- **Write request:** `s_axil[i].awvalid_i`. A `wvalid_i` without `awvalid_i` is not a request.
- **IDLE:**
  - If any request is present, the arbiter selects a winner, registers it in the grant index and moves to ADDR.
  - No ready signal is asserted to anyone while in IDLE.
- **Read ADDR:**
  - `m_axil.araddr/arvalid` are combinationally driven from `s_axil[rgnt]`.
  - `arready` is returned only to `s_axil[rgnt]`.
  - On `ar_handshake` the FSM moves to RESP.
- **Write ADDR:**
  - AW and W of `s_axil[wgnt]` are passed through to `m_axil`.
  - Sticky flags `aw_done` and `w_done` record each handshake. A done channel is masked: its downstream valid is 0 and its upstream ready is 0.
  - When both flags are set (same cycle or different cycles), the FSM moves to RESP and clears the flags.
- **RESP:**
  - `rdata/rresp/rvalid` (or `bresp/bvalid`) are passed to the granted master, and `rready`/`bready` are passed back from it.
  - On `r_handshake`/`b_handshake` the FSM returns to IDLE.
- **Non-granted masters** always see:
  - `arready = awready = wready = 0`;
  - `rvalid = bvalid = 0`;
  - `rdata = 0`, `rresp = 0`, `bresp = 0`.
- **Selection:** round-robin over the request vector, starting from `last_grant+1` modulo `N_MASTERS`. `last_grant` is updated when the FSM enters ADDR. Reads and writes keep separate pointers. See Configuration for the compile-time alternative.
- **Simultaneous read and write** from the same or different masters proceed concurrently and never block each other.
- **Response codes** from the slave are forwarded unchanged. The arbiter never generates SLVERR or DECERR itself.

## Timing
- **Arbitration latency:** a request seen in IDLE at edge k produces a downstream valid in the cycle after edge k, i.e. one bubble cycle.
- **Address/data/response path:** zero added latency; downstream valid/ready are combinational with the upstream ones in ADDR and RESP.
- **Back-to-back transactions:** RESP→IDLE→ADDR. The minimum spacing is 1 idle cycle between the response handshake and the next downstream valid.
- **Reset** (`rst_i` = 1 at an edge):
  - both FSMs go to IDLE;
  - both pointers go to 0, so master 0 wins first;
  - `aw_done` and `w_done` clear.
- **Outputs while in reset or IDLE:**
  - All `m_axil` outputs (`araddr`, `arvalid`, `awaddr`, `awvalid`, `wdata`, `wstrb`, `wvalid`, `rready`, `bready`) are 0.
  - All `s_axil` outputs are 0.
- **Reset mid-transaction:** the transaction is abandoned without a response. Upstream masters must also be reset. A late slave response arriving in IDLE is ignored: `rready`/`bready` stay 0.
- **Request withdrawal:** a master that drops `arvalid`/`awvalid` after the grant violates AXI. The SVA in `vga_axil_if` flags it; the arbiter behaviour is unspecified.

## Configuration
- **`VGA_AXIL_ARBITER_RR_EN` defined:** round-robin selection with per-path last-grant pointers, as described above.
- **`VGA_AXIL_ARBITER_RR_EN` not defined:**
  - fixed priority: the lowest requesting index always wins;
  - pointer registers are not instantiated;
  - all other behaviour is identical.

## Test plan
- **Single read:** with `N_MASTERS`=2, master 1 reads 0x10 while the slave returns 0xDEADBEEF/OKAY.
  - `m_axil.arvalid` rises 1 cycle after `s_axil[1].arvalid`.
  - Master 1 receives 0xDEADBEEF/OKAY.
  - Master 0 sees `rvalid`=0 throughout.
- **Split write:** master 0 writes 0x5A5A0001 to 0x04, with W issued 3 cycles after AW.
  - Exactly one AW handshake and one W handshake occur downstream.
  - `bvalid` reaches master 0 only.
- **Contention:** both masters request writes continuously for 4 transactions.
  - RR build: grant order 0,1,0,1.
  - Fixed build: grant order 0,0,0,0 while master 0 keeps requesting.
- **Concurrency:** master 0 writes 0x08 while master 1 reads 0x0C in the same cycle. Both complete, and neither FSM stalls the other.
- **Reset mid-write:** assert `rst_i` in RESP before `bvalid`.
  - The next cycle, all outputs are 0 and the write FSM is in IDLE.
  - A following read by master 1 is granted and completes normally.
- **Slave backpressure:** the slave holds `arready`=0 for 5 cycles.
  - `araddr`/`arvalid` stay stable.
  - Master 0's new request is not granted until master 1's R handshake completes.
